// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM with memory wait timeout.
// Optional: define ILLEGAL_OP_TRAP_EN to halt on unknown opcodes.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       bus_err,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef ILLEGAL_OP_TRAP_EN
    , S_HALT   = 4'd11
`endif
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait;
  logic             w_to;
  logic             w_pcupd;
  logic             w_branch;

  assign w_wait = (r_state == S_FETCH) ||
                  (r_state == S_MEMREAD) ||
                  (r_state == S_MEMWRITE);

  // Ready in the limit cycle wins over the timeout.
  assign w_to = (TIMEOUT > 0) && w_wait &&
                !mem_ready && (r_cnt == LIM);

  always_comb begin
    w_nxt = S_FETCH;
    unique case (r_state)
      S_FETCH:    w_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  w_nxt = S_MEMADR;
          (op == OP_R):   w_nxt = S_EXECR;
          (op == OP_I):   w_nxt = S_EXECI;
          (op == OP_BEQ): w_nxt = S_BEQ;
          (op == OP_JAL): w_nxt = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:        w_nxt = S_HALT;
`else
          default:        w_nxt = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:
        w_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_nxt = S_FETCH;
      S_MEMWRITE: w_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_nxt = S_ALUWB;
      S_EXECI:    w_nxt = S_ALUWB;
      S_ALUWB:    w_nxt = S_FETCH;
      S_BEQ:      w_nxt = S_FETCH;
      S_JAL:      w_nxt = S_ALUWB;
`ifdef ILLEGAL_OP_TRAP_EN
      S_HALT:     w_nxt = S_HALT;
`endif
      default:    w_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      if (w_wait && !mem_ready && !w_to)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;
      r_state <= w_to ? S_FETCH : w_nxt;
    end
  end

  always_comb begin
    w_pcupd   = 1'b0;
    w_branch  = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        w_pcupd   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = !w_to;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        w_branch = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcupd = 1'b1;
      end
      default: ;
    endcase
    PCWrite = w_pcupd | (w_branch & zero);
    unique case (1'b1)
      (op == OP_SW):  ImmSrc = 2'b01;
      (op == OP_BEQ): ImmSrc = 2'b10;
      (op == OP_JAL): ImmSrc = 2'b11;
      default:        ImmSrc = 2'b00;
    endcase
    bus_err = w_to;
    if (!rst) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      ImmSrc    = 2'b00;
      RegWrite  = 1'b0;
      bus_err   = 1'b0;
    end
  end

  assign state_o = rst ? r_state : 4'd0;

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = rst && (r_state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences a shared-memory multi-cycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal). Replaces per-instruction combinational decode with one state per datapath phase. Stalls on a memory ready handshake and flags stuck memory accesses via a timeout counter. Sits beside the ALU decoder, which consumes ALUOp.

Parameters:
TIMEOUT, 16, max consecutive wait cycles on mem_ready before bus_err; 0 disables the timeout.
CNT_W, 5, width of wait counter; must hold TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
op  in  7  instruction opcode (Instr[6:0]), valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction / OldPC register enable
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 ImmExt, 10 constant 4
ALUOp  out  2  00 add, 01 sub (branch), 10 funct-decoded
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; decoded combinationally from op, 00 for unknown op
RegWrite  out  1  register file write enable
bus_err  out  1  one-cycle pulse on memory timeout
illegal  out  1  illegal-opcode flag (see Optional Feature)
state_o  out  4  current state encoding, debug

Behaviour:
- While rst = 0: state <= FETCH, wait counter <= 0; all outputs driven 0 (write enables gated by reset).
- Unlisted outputs are 0 in each state. PCWrite = PCUpdate | (Branch & zero).
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
  - lw/sw -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - other -> FETCH
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Stay until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB (writes rd = PC+4).
- Latency (cycles, zero wait): lw 5, sw 4, R/I 4, beq 3, jal 4. Each memory wait cycle adds 1.
- Wait counter:
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE with mem_ready=0.
  - Clears on mem_ready or on any other state.
  - When count reaches TIMEOUT (TIMEOUT>0): bus_err=1 for one cycle, counter clears, state -> FETCH. No RegWrite/IRWrite is issued for the aborted access. MemWrite drops the same cycle.
  - mem_ready=1 in the timeout cycle: ready wins and the access completes normally, no bus_err.
- Async reset mid-instruction: abandon immediately, outputs 0, resume at FETCH after release.

Optional Feature:
ILLEGAL_OP_TRAP_EN.
- Defined: unknown op in DECODE -> HALT. HALT drives all enables 0 and illegal=1, and is held until reset.
- Undefined: unknown op returns to FETCH (NOP semantics). HALT does not exist; illegal tied 0.

Test Plan:
- Reset, mem_ready=1 -> all outputs 0 during reset. First cycle after release: FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op 0000011), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 and ResultSrc=01 only in cycle 5. ImmSrc=00.
- sw with mem_ready held 0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, ImmSrc=01, then FETCH; RegWrite never 1.
- beq with zero=1 vs zero=0 -> PCWrite=1 vs 0 in BEQ cycle. ALUOp=01, ImmSrc=10.
- jal (1101111) -> PCWrite=1 in JAL, then ALUWB with RegWrite=1, ResultSrc=00. Total 4 cycles.
- FETCH with mem_ready=0 for 16 cycles (TIMEOUT=16) -> bus_err pulse on cycle 16, IRWrite never 1. Unknown op 1111111 -> FETCH, or HALT with illegal=1 when ILLEGAL_OP_TRAP_EN is defined.
